// File: rtl/axis_frame_len_arb.sv
// axis_frame_len_arb
//   Shares one frame-length reporting stream between PORTS frame-length monitors.
//   Each monitor strobe is captured into a one-entry slot for its port. A
//   round-robin arbiter moves pending slots into a single output register that
//   feeds a valid/ready stream tagged with the source port. A report that
//   arrives while its port's slot is still occupied is discarded and counted
//   in a per-port saturating drop counter.
//
// Ports
//   clk                 clock, all logic on the rising edge
//   rst_n               asynchronous active-low reset
//   in_frame_len        port i length at [i*LEN_WIDTH +: LEN_WIDTH]
//   in_frame_len_valid  one-cycle report strobe per port
//   out_len, out_id     granted frame length and its source port
//   out_valid           output register holds a report
//   out_ready           consumer accepts when out_valid && out_ready
//   pending             slot i holds an unsent report
//   drop_count          port i drops at [i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH]
//   drop_clear          synchronous clear of all drop counters
module axis_frame_len_arb #(
  parameter int PORTS          = 4,
  parameter int LEN_WIDTH      = 16,
  parameter int DROP_CNT_WIDTH = 8,
  parameter int ID_WIDTH       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PORTS*LEN_WIDTH-1:0]      in_frame_len,
  input  logic [PORTS-1:0]                in_frame_len_valid,
  output logic [LEN_WIDTH-1:0]            out_len,
  output logic [ID_WIDTH-1:0]             out_id,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PORTS-1:0]                pending,
  output logic [PORTS*DROP_CNT_WIDTH-1:0] drop_count,
  input  logic                            drop_clear
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                    state;
  logic [ID_WIDTH-1:0]       ptr;
  logic [PORTS-1:0]          slot_full;
  logic [LEN_WIDTH-1:0]      slot_len [PORTS];
  logic [DROP_CNT_WIDTH-1:0] drop_cnt [PORTS];

  logic                      load;
  logic                      grant_found;
  logic [ID_WIDTH-1:0]       grant_idx;
  logic [PORTS-1:0]          take;
  logic [PORTS-1:0]          capture;
  logic [PORTS-1:0]          drop;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    return (v == {DROP_CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  // The output register may take a new report when empty, or when its current
  // report is being accepted this cycle (back-to-back beats without a bubble).
  assign load = (state == EMPTY) || out_ready;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = ID_WIDTH'((int'(ptr) + k) % PORTS);
      if (!grant_found && slot_full[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // A slot being granted this cycle is free to accept a new strobe, so a
  // report arriving on the granted port is captured instead of dropped.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      take[i]    = load && grant_found && (grant_idx == ID_WIDTH'(i));
      capture[i] = in_frame_len_valid[i] && (!slot_full[i] || take[i]);
      drop[i]    = in_frame_len_valid[i] && slot_full[i] && !take[i];
    end
  end

  // ---- capture stage: per-port slots ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (capture[i])   slot_full[i] <= 1'b1;
        else if (take[i]) slot_full[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (capture[i]) slot_len[i] <= in_frame_len[i*LEN_WIDTH +: LEN_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PORTS; i++) drop_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (drop_clear)   drop_cnt[i] <= DROP_CNT_WIDTH'(drop[i]);
        else if (drop[i]) drop_cnt[i] <= sat_inc(drop_cnt[i]);
      end
    end
  end

  // ---- output stage: arbitrated register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      out_len <= '0;
      out_id  <= '0;
      ptr     <= ID_WIDTH'(PORTS - 1);
    end else if (load) begin
      if (grant_found) begin
        state   <= FULL;
        out_len <= slot_len[grant_idx];
        out_id  <= grant_idx;
        ptr     <= grant_idx;
      end else begin
        state   <= EMPTY;
      end
    end
  end

  assign out_valid = (state == FULL);
  assign pending   = slot_full;

  for (genvar g = 0; g < PORTS; g++) begin : g_drop
    assign drop_count[g*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_cnt[g];
  end

endmodule
